dcache_write_checker: RTL and testbench

- Parametrised successor to the single-purpose result checker on the CHIP's DCACHE observation port (`addr`/`data`/`wen`).
- Holds a loadable table of expected (address, data) writes and compares processor writes against it, either in order or by address match.
- Counts mismatches, measures run duration in cycles and raises `finish` or `timeout`.
- Sits beside CHIP in the simulation top level. It is also synthesizable, for on-FPGA self-check.

---
 rtl/dcache_chk_pkg.sv | 27 ++
 rtl/dcache_write_checker_table.sv | 69 ++++++
 rtl/dcache_write_checker.sv | 199 +++++++++++++++++++
 tb/tb_dcache_write_checker.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_chk_pkg.sv
// Shared types and helpers for the DCACHE write checker.
// Holds the state encoding, saturating-increment helpers and the "no error yet" index marker.
package dcache_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    TMO  = 2'd3
  } chk_state_e;

  // first_err_idx value when no mismatch has been seen (truncated to the port width)
  localparam logic [31:0] NO_ERR_IDX = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_max(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] err_sat(input logic [31:0] cnt, input int unsigned w);
    return (cnt >= sat_max(w)) ? sat_max(w) : cnt + 32'd1;
  endfunction

  function automatic logic [31:0] dur_sat(input logic [31:0] cnt, input int unsigned w);
    return (cnt >= sat_max(w)) ? sat_max(w) : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/dcache_write_checker_table.sv
// Expected-write table: DEPTH (addr, data) entries, a per-entry hit bit, an indexed read port
// and a priority search returning the lowest valid, not-yet-hit entry whose address matches.
module chk_table
  import dcache_chk_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_idx,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  input  logic [ADDR_W-1:0]          srch_addr,
  input  logic [$clog2(DEPTH):0]     srch_count,
  output logic                       srch_hit,
  output logic [$clog2(DEPTH)-1:0]   srch_idx,
  output logic [DATA_W-1:0]          srch_data,
  input  logic                       hit_set,
  input  logic [$clog2(DEPTH)-1:0]   hit_idx,
  input  logic                       hit_clr
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [ADDR_W-1:0] tab_addr [DEPTH];
  logic [DATA_W-1:0] tab_data [DEPTH];
  logic [DEPTH-1:0]  hit_q;

  // table contents deliberately survive reset so a run can be repeated without reloading
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tab_addr[wr_idx] <= wr_addr;
      tab_data[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || hit_clr) begin
      hit_q <= '0;
    end else if (hit_set) begin
      hit_q[hit_idx] <= 1'b1;
    end
  end

  assign rd_addr = tab_addr[rd_idx];
  assign rd_data = tab_data[rd_idx];

  // descending scan so the lowest matching index is the one left standing
  always_comb begin
    srch_hit = 1'b0;
    srch_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((CNT_W'(i) < srch_count) && !hit_q[i] && (tab_addr[i] == srch_addr)) begin
        srch_hit = 1'b1;
        srch_idx = IDX_W'(i);
      end
    end
  end

  assign srch_data = tab_data[srch_idx];

endmodule

// File: rtl/dcache_write_checker.sv
// DCACHE write checker: compares observed processor writes with a loaded table of expected
// writes (in order or by address), counting mismatches and timing the run.
module dcache_write_checker
  import dcache_chk_pkg::*;
#(
  parameter int              ADDR_W     = 30,
  parameter int              DATA_W     = 32,
  parameter int              DEPTH      = 64,
  parameter int              ERR_W      = 8,
  parameter int              DUR_W      = 16,
  parameter int              TIMEOUT    = 65535,
  parameter logic [ADDR_W-1:0] CHECK_BASE = '0,
  parameter bit              ORDERED    = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_idx,
  input  logic [ADDR_W-1:0]          cfg_addr,
  input  logic [DATA_W-1:0]          cfg_data,
  input  logic [$clog2(DEPTH):0]     cfg_count,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          data,
  input  logic                       wen,
  output logic                       busy,
  output logic [ERR_W-1:0]           error_num,
  output logic [DUR_W-1:0]           duration,
  output logic                       finish,
  output logic                       timeout,
  output logic [$clog2(DEPTH):0]     first_err_idx
);

  // state | meaning
  // IDLE  | table loadable, waiting for start
  // RUN   | observing and comparing DCACHE writes
  // DONE  | every expected write seen, finish held
  // TMO   | TIMEOUT cycles elapsed without completion, timeout held

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  chk_state_e         state_q, state_d;
  logic               start_ok;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   prog_q;
  logic [ERR_W-1:0]   err_q;
  logic [DUR_W-1:0]   dur_q;
  logic [TMO_W-1:0]   tmo_q;
  logic               finish_q;
  logic               timeout_q;
  logic [CNT_W-1:0]   first_err_q;
  logic               p_vld_q;
  logic [ADDR_W-1:0]  p_addr_q;
  logic [DATA_W-1:0]  p_data_q;

  logic [ADDR_W-1:0]  rd_addr;
  logic [DATA_W-1:0]  rd_data;
  logic               srch_hit;
  logic [IDX_W-1:0]   srch_idx;
  logic [DATA_W-1:0]  srch_data;

  logic               cmp_err;
  logic               cmp_adv;
  logic [CNT_W-1:0]   cmp_idx;
  logic               complete;
  logic               tmo_hit;
  logic               in_run;

  chk_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (cfg_we && (state_q == IDLE)),
    .wr_idx     (cfg_idx),
    .wr_addr    (cfg_addr),
    .wr_data    (cfg_data),
    .rd_idx     (prog_q[IDX_W-1:0]),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .srch_addr  (p_addr_q),
    .srch_count (cnt_q),
    .srch_hit   (srch_hit),
    .srch_idx   (srch_idx),
    .srch_data  (srch_data),
    .hit_set    (!ORDERED && p_vld_q && srch_hit),
    .hit_idx    (srch_idx),
    .hit_clr    (start_ok)
  );

  assign in_run = (state_q == RUN);

  // prog_q is the in-order pointer when ORDERED, otherwise the matched-entry count
  always_comb begin
    cmp_err = 1'b0;
    cmp_adv = 1'b0;
    cmp_idx = prog_q;
    if (p_vld_q) begin
      if (ORDERED) begin
        cmp_adv = 1'b1;
        cmp_err = (rd_addr != p_addr_q) || (rd_data != p_data_q);
        cmp_idx = prog_q;
      end else if (srch_hit) begin
        cmp_adv = 1'b1;
        cmp_err = (srch_data != p_data_q);
        cmp_idx = CNT_W'(srch_idx);
      end else begin
        cmp_err = 1'b1;
        cmp_idx = cnt_q;
      end
    end
  end

  assign complete = cmp_adv && ((prog_q + CNT_W'(1)) == cnt_q);
  assign tmo_hit  = in_run && (tmo_q == TMO_W'(1));

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    case (state_q)
      IDLE, DONE, TMO: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = (cfg_count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (complete) begin
          state_d = DONE;
        end else if (tmo_hit) begin
          state_d = TMO;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prog_q      <= '0;
      err_q       <= '0;
      dur_q       <= '0;
      tmo_q       <= '0;
      finish_q    <= 1'b0;
      timeout_q   <= 1'b0;
      first_err_q <= CNT_W'(NO_ERR_IDX);
      p_vld_q     <= 1'b0;
      p_addr_q    <= '0;
      p_data_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        cnt_q       <= cfg_count;
        prog_q      <= '0;
        err_q       <= '0;
        dur_q       <= '0;
        tmo_q       <= TMO_W'(TIMEOUT);
        finish_q    <= (cfg_count == '0);
        timeout_q   <= 1'b0;
        first_err_q <= CNT_W'(NO_ERR_IDX);
        p_vld_q     <= 1'b0;
      end else if (in_run) begin
        dur_q <= DUR_W'(dur_sat(32'(dur_q), DUR_W));
        tmo_q <= tmo_q - TMO_W'(1);
        if (cmp_adv) begin
          prog_q <= prog_q + CNT_W'(1);
        end
        if (cmp_err) begin
          err_q <= ERR_W'(err_sat(32'(err_q), ERR_W));
          // error_num saturates and never wraps, so zero means no error recorded yet
          if (err_q == '0) begin
            first_err_q <= cmp_idx;
          end
        end
        finish_q  <= complete;
        timeout_q <= !complete && tmo_hit;
        p_vld_q   <= wen && (addr >= CHECK_BASE) && !complete && !tmo_hit;
        p_addr_q  <= addr;
        p_data_q  <= data;
      end else begin
        p_vld_q <= 1'b0;
      end
    end
  end

  assign busy          = in_run;
  assign error_num     = err_q;
  assign duration      = dur_q;
  assign finish        = finish_q;
  assign timeout       = timeout_q;
  assign first_err_idx = first_err_q;

endmodule

// File: tb/tb_dcache_write_checker.sv
// Bench for dcache_write_checker: an in-order instance (TIMEOUT=20, CHECK_BASE=0x100) and an
// any-order instance share stimulus; directed scenarios plus random runs against a reference model.
module tb_dcache_write_checker;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int IDX_W  = 6;
  localparam int CNT_W  = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1, cfg_we = 1'b0, start = 1'b0, wen = 1'b0;
  logic [IDX_W-1:0]  cfg_idx = '0;
  logic [ADDR_W-1:0] cfg_addr = '0, addr = '0;
  logic [DATA_W-1:0] cfg_data = '0, data = '0;
  logic [CNT_W-1:0]  cfg_count = '0;

  logic o_busy, o_finish, o_timeout, u_busy, u_finish, u_timeout;
  logic [7:0]       o_err, u_err;
  logic [15:0]      o_dur, u_dur;
  logic [CNT_W-1:0] o_fei, u_fei;

  int errors = 0;
  int checks = 0;

  int                s_cyc[$];
  logic [ADDR_W-1:0] s_addr[$];
  logic [DATA_W-1:0] s_data[$];
  logic [ADDR_W-1:0] t_addr[DEPTH];
  logic [DATA_W-1:0] t_data[DEPTH];

  dcache_write_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .ERR_W(8), .DUR_W(16),
    .TIMEOUT(20), .CHECK_BASE(30'h100), .ORDERED(1'b1)
  ) u_ord (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_count(cfg_count), .start(start), .addr(addr), .data(data),
    .wen(wen), .busy(o_busy), .error_num(o_err), .duration(o_dur), .finish(o_finish),
    .timeout(o_timeout), .first_err_idx(o_fei)
  );

  dcache_write_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .ERR_W(8), .DUR_W(16),
    .TIMEOUT(65535), .CHECK_BASE(30'h0), .ORDERED(1'b0)
  ) u_uno (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_count(cfg_count), .start(start), .addr(addr), .data(data),
    .wen(wen), .busy(u_busy), .error_num(u_err), .duration(u_dur), .finish(u_finish),
    .timeout(u_timeout), .first_err_idx(u_fei)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load(input int idx, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
    t_addr[idx] = a;
    t_data[idx] = d;
  endtask

  task automatic load3();
    load(0, 30'h100, 32'd1);
    load(1, 30'h104, 32'd2);
    load(2, 30'h108, 32'd3);
  endtask

  task automatic sched_clear();
    s_cyc.delete(); s_addr.delete(); s_data.delete();
  endtask

  task automatic sched_add(input int c, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    s_cyc.push_back(c); s_addr.push_back(a); s_data.push_back(d);
  endtask

  // start in cycle 0, then run cycles 1..len; returns just after the edge closing cycle len
  task automatic run_sched(input int cnt, input int len);
    int k;
    k = 0;
    cfg_count = CNT_W'(cnt);
    start = 1'b1;
    wen = 1'b0;
    if (k < s_cyc.size() && s_cyc[k] == 0) begin
      wen = 1'b1; addr = s_addr[k]; data = s_data[k]; k++;
    end
    tick();
    start = 1'b0;
    for (int c = 1; c <= len; c++) begin
      wen = 1'b0;
      if (k < s_cyc.size() && s_cyc[k] == c) begin
        wen = 1'b1; addr = s_addr[k]; data = s_data[k]; k++;
      end
      tick();
    end
    wen = 1'b0;
  endtask

  // Reference: each qualifying write observed in cycle w is judged at the end of cycle w+1;
  // the run ends at completion or at cycle tmo, whichever comes first (completion wins ties).
  task automatic model_run(input bit ordered, input int base, input int tmo, input int cnt,
                           input int len, output int e_err, output int e_fei, output int e_fin,
                           output int e_to, output int e_dur, output int e_busy);
    bit hit[DEPTH];
    int prog, endc, idx, w, cmpc, found;
    bit mis, done;
    prog = 0; e_err = 0; e_fei = 127; done = 0; endc = 0;
    for (int j = 0; j < DEPTH; j++) hit[j] = 0;
    for (int k = 0; k < s_cyc.size(); k++) begin
      w = s_cyc[k];
      if (w < 1 || int'(s_addr[k]) < base) continue;
      cmpc = w + 1;
      if (cmpc > tmo || cmpc > len) break;
      if (ordered) begin
        mis = (s_addr[k] != t_addr[prog]) || (s_data[k] != t_data[prog]);
        idx = prog;
        prog++;
      end else begin
        found = -1;
        for (int j = 0; j < cnt; j++)
          if (found < 0 && !hit[j] && t_addr[j] == s_addr[k]) found = j;
        if (found >= 0) begin
          mis = (s_data[k] != t_data[found]);
          hit[found] = 1;
          idx = found;
          prog++;
        end else begin
          mis = 1;
          idx = cnt;
        end
      end
      if (mis) begin
        if (e_err == 0) e_fei = idx;
        if (e_err < 255) e_err++;
      end
      if (prog == cnt) begin
        done = 1; endc = cmpc;
        break;
      end
    end
    if (done) begin
      e_fin = 1; e_to = 0; e_dur = endc; e_busy = 0;
    end else if (len >= tmo) begin
      e_fin = 0; e_to = 1; e_dur = tmo; e_busy = 0;
    end else begin
      e_fin = 0; e_to = 0; e_dur = len; e_busy = 1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_busy !== 1'b0 || o_finish !== 1'b0 || o_timeout !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%0b fin=%0b to=%0b want 0 0 0", o_busy, o_finish, o_timeout); end
    checks++; if (o_err !== 8'd0 || o_dur !== 16'd0) begin errors++; $display("FAIL reset_counts got err=%0d dur=%0d want 0 0", o_err, o_dur); end
    checks++; if (o_fei !== 7'h7F || u_fei !== 7'h7F) begin errors++; $display("FAIL reset_fei got %0h/%0h want 7f", o_fei, u_fei); end
  endtask

  task automatic test_ordered_exact();
    do_reset(); load3();
    sched_clear();
    sched_add(5, 30'h100, 32'd1); sched_add(9, 30'h104, 32'd2); sched_add(14, 30'h108, 32'd3);
    run_sched(3, 14);
    checks++; if (o_finish !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL exact_pre got fin=%0b busy=%0b want 0 1", o_finish, o_busy); end
    tick();
    checks++; if (o_finish !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL exact_fin got fin=%0b busy=%0b want 1 0", o_finish, o_busy); end
    checks++; if (o_err !== 8'd0 || o_dur !== 16'd15) begin errors++; $display("FAIL exact_cnt got err=%0d dur=%0d want 0 15", o_err, o_dur); end
    checks++; if (o_fei !== 7'h7F) begin errors++; $display("FAIL exact_fei got %0h want 7f", o_fei); end
    checks++; if (u_finish !== 1'b1 || u_err !== 8'd0 || u_dur !== 16'd15) begin errors++; $display("FAIL exact_uno got fin=%0b err=%0d dur=%0d want 1 0 15", u_finish, u_err, u_dur); end
    tick(); tick();
    checks++; if (o_finish !== 1'b1 || o_dur !== 16'd15) begin errors++; $display("FAIL exact_sticky got fin=%0b dur=%0d want 1 15", o_finish, o_dur); end
  endtask

  task automatic test_ordered_data_err();
    do_reset(); load3();
    sched_clear();
    sched_add(5, 30'h100, 32'd1); sched_add(9, 30'h104, 32'd7); sched_add(14, 30'h108, 32'd3);
    run_sched(3, 15);
    checks++; if (o_err !== 8'd1 || o_fei !== 7'd1 || o_finish !== 1'b1) begin errors++; $display("FAIL data_err got err=%0d fei=%0d fin=%0b want 1 1 1", o_err, o_fei, o_finish); end
    checks++; if (u_err !== 8'd1 || u_fei !== 7'd1 || u_finish !== 1'b1) begin errors++; $display("FAIL data_err_uno got err=%0d fei=%0d fin=%0b want 1 1 1", u_err, u_fei, u_finish); end
  endtask

  task automatic test_unordered();
    do_reset(); load3();
    sched_clear();
    sched_add(2, 30'h108, 32'd3); sched_add(4, 30'h200, 32'd9);
    sched_add(6, 30'h100, 32'd1); sched_add(8, 30'h104, 32'd2);
    run_sched(3, 8);
    checks++; if (u_finish !== 1'b0 || u_busy !== 1'b1) begin errors++; $display("FAIL uno_pre got fin=%0b busy=%0b want 0 1", u_finish, u_busy); end
    checks++; if (o_finish !== 1'b1 || o_err !== 8'd3 || o_fei !== 7'd0 || o_dur !== 16'd7) begin errors++; $display("FAIL uno_ord got fin=%0b err=%0d fei=%0d dur=%0d want 1 3 0 7", o_finish, o_err, o_fei, o_dur); end
    tick();
    checks++; if (u_finish !== 1'b1 || u_err !== 8'd1 || u_fei !== 7'd3 || u_dur !== 16'd9) begin errors++; $display("FAIL uno got fin=%0b err=%0d fei=%0d dur=%0d want 1 1 3 9", u_finish, u_err, u_fei, u_dur); end
  endtask

  task automatic test_timeout();
    do_reset(); load3();
    sched_clear();
    sched_add(3, 30'h100, 32'd1);
    run_sched(2, 19);
    checks++; if (o_timeout !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL tmo_pre got to=%0b busy=%0b want 0 1", o_timeout, o_busy); end
    tick();
    checks++; if (o_timeout !== 1'b1 || o_finish !== 1'b0 || o_busy !== 1'b0 || o_dur !== 16'd20) begin errors++; $display("FAIL tmo got to=%0b fin=%0b busy=%0b dur=%0d want 1 0 0 20", o_timeout, o_finish, o_busy, o_dur); end
    wen = 1'b1; addr = 30'h104; data = 32'd2;
    tick(); tick();
    wen = 1'b0;
    checks++; if (o_timeout !== 1'b1 || o_dur !== 16'd20 || o_err !== 8'd0) begin errors++; $display("FAIL tmo_sticky got to=%0b dur=%0d err=%0d want 1 20 0", o_timeout, o_dur, o_err); end
  endtask

  task automatic test_check_base();
    do_reset(); load3();
    sched_clear();
    sched_add(2, 30'h100, 32'd1); sched_add(3, 30'h0FC, 32'd5);
    sched_add(5, 30'h104, 32'd2); sched_add(7, 30'h108, 32'd3);
    run_sched(3, 8);
    checks++; if (o_finish !== 1'b1 || o_err !== 8'd0 || o_dur !== 16'd8) begin errors++; $display("FAIL base got fin=%0b err=%0d dur=%0d want 1 0 8", o_finish, o_err, o_dur); end
    checks++; if (u_finish !== 1'b1 || u_err !== 8'd1 || u_fei !== 7'd3) begin errors++; $display("FAIL base_uno got fin=%0b err=%0d fei=%0d want 1 1 3", u_finish, u_err, u_fei); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < DEPTH; i++) load(i, ADDR_W'(32'h400 + 4 * i), DATA_W'(i));
    sched_clear();
    for (int i = 1; i <= 300; i++) sched_add(i, 30'h300, 32'd0);
    for (int i = 0; i < DEPTH; i++) sched_add(301 + i, ADDR_W'(32'h400 + 4 * i), DATA_W'(i));
    run_sched(DEPTH, 364);
    checks++; if (u_err !== 8'd255 || u_finish !== 1'b0 || u_busy !== 1'b1) begin errors++; $display("FAIL sat_pre got err=%0d fin=%0b busy=%0b want 255 0 1", u_err, u_finish, u_busy); end
    tick();
    checks++; if (u_finish !== 1'b1 || u_err !== 8'd255 || u_fei !== 7'd64 || u_dur !== 16'd365) begin errors++; $display("FAIL sat got fin=%0b err=%0d fei=%0d dur=%0d want 1 255 64 365", u_finish, u_err, u_fei, u_dur); end
  endtask

  task automatic test_mid_run_reset();
    do_reset(); load3();
    sched_clear();
    sched_add(2, 30'h100, 32'd1); sched_add(4, 30'h104, 32'd2);
    run_sched(3, 6);
    checks++; if (o_busy !== 1'b1 || u_busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %0b/%0b want 1", o_busy, u_busy); end
    do_reset();
    checks++; if (o_busy !== 1'b0 || o_finish !== 1'b0 || o_timeout !== 1'b0 || o_err !== 8'd0 || o_dur !== 16'd0 || o_fei !== 7'h7F) begin errors++; $display("FAIL mid_rst_ord got busy=%0b fin=%0b to=%0b err=%0d dur=%0d fei=%0h want 0 0 0 0 0 7f", o_busy, o_finish, o_timeout, o_err, o_dur, o_fei); end
    checks++; if (u_busy !== 1'b0 || u_finish !== 1'b0 || u_dur !== 16'd0 || u_fei !== 7'h7F) begin errors++; $display("FAIL mid_rst_uno got busy=%0b fin=%0b dur=%0d fei=%0h want 0 0 0 7f", u_busy, u_finish, u_dur, u_fei); end
    sched_clear();
    sched_add(5, 30'h100, 32'd1); sched_add(9, 30'h104, 32'd2); sched_add(14, 30'h108, 32'd3);
    run_sched(3, 15);
    checks++; if (o_finish !== 1'b1 || o_err !== 8'd0 || o_dur !== 16'd15) begin errors++; $display("FAIL mid_rerun got fin=%0b err=%0d dur=%0d want 1 0 15", o_finish, o_err, o_dur); end
    checks++; if (u_finish !== 1'b1 || u_err !== 8'd0) begin errors++; $display("FAIL mid_rerun_uno got fin=%0b err=%0d want 1 0", u_finish, u_err); end
  endtask

  task automatic test_zero_count();
    sched_clear();
    sched_add(0, 30'h100, 32'd1);
    run_sched(0, 0);
    checks++; if (o_finish !== 1'b1 || o_dur !== 16'd0 || o_busy !== 1'b0 || o_err !== 8'd0) begin errors++; $display("FAIL zero got fin=%0b dur=%0d busy=%0b err=%0d want 1 0 0 0", o_finish, o_dur, o_busy, o_err); end
    checks++; if (u_finish !== 1'b1 || u_dur !== 16'd0 || u_timeout !== 1'b0) begin errors++; $display("FAIL zero_uno got fin=%0b dur=%0d to=%0b want 1 0 0", u_finish, u_dur, u_timeout); end
  endtask

  task automatic test_random();
    int cnt, c, len, r;
    int e_err, e_fei, e_fin, e_to, e_dur, e_busy;
    logic [ADDR_W-1:0] a;
    for (int it = 0; it < 30; it++) begin
      do_reset();
      cnt = $urandom_range(1, 4);
      for (int i = 0; i < cnt + 2; i++)
        load(i, ADDR_W'(32'h100 + 4 * $urandom_range(0, 5)), DATA_W'($urandom_range(0, 3)));
      sched_clear();
      c = $urandom_range(0, 2);
      while (c <= 25) begin
        r = $urandom_range(0, 99);
        if (r < 70) a = ADDR_W'(32'h100 + 4 * $urandom_range(0, 5));
        else if (r < 85) a = 30'h0F0;
        else a = 30'h200;
        sched_add(c, a, DATA_W'($urandom_range(0, 3)));
        c += $urandom_range(1, 3);
      end
      len = 30;
      run_sched(cnt, len);
      model_run(1'b1, 32'h100, 20, cnt, len, e_err, e_fei, e_fin, e_to, e_dur, e_busy);
      checks++; if (o_err !== 8'(e_err) || o_fei !== 7'(e_fei) || o_finish !== 1'(e_fin) || o_timeout !== 1'(e_to) || o_dur !== 16'(e_dur) || o_busy !== 1'(e_busy)) begin errors++; $display("FAIL rand_ord it=%0d got err=%0d fei=%0d fin=%0b to=%0b dur=%0d busy=%0b want %0d %0d %0d %0d %0d %0d", it, o_err, o_fei, o_finish, o_timeout, o_dur, o_busy, e_err, e_fei, e_fin, e_to, e_dur, e_busy); end
      model_run(1'b0, 0, 65535, cnt, len, e_err, e_fei, e_fin, e_to, e_dur, e_busy);
      checks++; if (u_err !== 8'(e_err) || u_fei !== 7'(e_fei) || u_finish !== 1'(e_fin) || u_timeout !== 1'(e_to) || u_dur !== 16'(e_dur) || u_busy !== 1'(e_busy)) begin errors++; $display("FAIL rand_uno it=%0d got err=%0d fei=%0d fin=%0b to=%0b dur=%0d busy=%0b want %0d %0d %0d %0d %0d %0d", it, u_err, u_fei, u_finish, u_timeout, u_dur, u_busy, e_err, e_fei, e_fin, e_to, e_dur, e_busy); end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ordered_exact();
    test_ordered_data_err();
    test_unordered();
    test_timeout();
    test_check_base();
    test_saturation();
    test_mid_run_reset();
    test_zero_count();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
